// File: rtl/mode_key_sequencer.sv
// mode_key_sequencer: debounced KEY[1:0] front end that steps
// the calculator MODE up/down by one per accepted press.
module mode_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic       MODE_STROBE,
  output logic [1:0] KEY_PRESSED
);

  typedef enum logic [1:0] {
    REL,
    PWAIT,
    PRS,
    RWAIT
  } kstate_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] press;

  kstate_t          st_q  [2];
  kstate_t          st_d  [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [1:0] mode_d;
  logic       strobe_d;

  // two-flop synchroniser; reset to the released level
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= KEY;
      s2 <= s1;
    end
  end

  // per-key debounce state and stability counters
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= REL;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // debounce transitions; a press event fires on the PWAIT commit
  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        REL: begin
          if (!s2[i]) begin
            st_d[i]  = PWAIT;
            cnt_d[i] = CNT_ONE;
          end
        end
        PWAIT: begin
          if (s2[i]) begin
            st_d[i]  = REL;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i]  = PRS;
            cnt_d[i] = '0;
            press[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRS: begin
          if (s2[i]) begin
            st_d[i]  = RWAIT;
            cnt_d[i] = CNT_ONE;
          end
        end
        RWAIT: begin
          if (!s2[i]) begin
            st_d[i]  = PRS;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i]  = REL;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          st_d[i]  = REL;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // resolve press events into the next mode; a tie clears to 0
  always_comb begin
    mode_d   = MODE;
    strobe_d = 1'b0;
    unique case (1'b1)
      press == 2'b11: begin
        mode_d   = 2'b00;
        strobe_d = 1'b1;
      end
      press == 2'b01: begin
        mode_d   = MODE + 2'd1;
        strobe_d = 1'b1;
      end
      press == 2'b10: begin
        mode_d   = MODE - 2'd1;
        strobe_d = 1'b1;
      end
      default: begin
        mode_d   = MODE;
        strobe_d = 1'b0;
      end
    endcase
  end

  // registered mode and its one-cycle update strobe
  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      MODE        <= 2'b00;
      MODE_STROBE <= 1'b0;
    end else begin
      MODE        <= mode_d;
      MODE_STROBE <= strobe_d;
    end
  end

  // debounced level: pressed while stable-pressed or release pending
  always_comb begin
    KEY_PRESSED = 2'b00;
    for (int i = 0; i < 2; i++) begin
      KEY_PRESSED[i] = (st_q[i] == PRS) || (st_q[i] == RWAIT);
    end
  end

endmodule

// File: tb/tb_mode_key_sequencer.sv
// tb_mode_key_sequencer: vector table plus scoreboard model
// and hand sequences for timing, bounce and reset corners.
module tb_mode_key_sequencer;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [1:0] key;
  logic [1:0] mode;
  logic       strobe;
  logic [1:0] kp;

  mode_key_sequencer #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET(rst),
    .KEY(key),
    .MODE(mode),
    .MODE_STROBE(strobe),
    .KEY_PRESSED(kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       stb;
    logic [1:0] kp;
  } exp_t;

  typedef struct {
    logic [1:0] key;
    int         cycles;
    logic [1:0] exp_mode;
    logic [1:0] exp_kp;
    int         exp_stb;
  } vec_t;

  exp_t sbq[$];

  int n_pass;
  int n_total;
  int stb_cnt;

  logic [1:0] md1;
  logic [1:0] md2;
  logic [1:0] mdeb;
  int         mrun [2];
  logic [1:0] mmode;
  logic       mstb;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    exp_t e;
    logic [1:0] ev;
    ev = 2'b00;
    if (rst) begin
      md1 = 2'b11;
      md2 = 2'b11;
      mdeb = 2'b00;
      mrun[0] = 0;
      mrun[1] = 0;
      mmode = 2'b00;
      mstb = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((!md2[i]) != mdeb[i]) begin
          mrun[i]++;
          if (mrun[i] == D + 1) begin
            mdeb[i] = !mdeb[i];
            mrun[i] = 0;
            ev[i] = mdeb[i];
          end
        end else begin
          mrun[i] = 0;
        end
      end
      md2 = md1;
      md1 = key;
      mstb = |ev;
      if (ev == 2'b11) mmode = 2'b00;
      else if (ev[0]) mmode = mmode + 2'd1;
      else if (ev[1]) mmode = mmode - 2'd1;
    end
    e.mode = mmode;
    e.stb = mstb;
    e.kp = mdeb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (strobe === 1'b1) stb_cnt++;
    check("sb", {3'b0, mode, strobe, kp},
          {3'b0, e.mode, e.stb, e.kp});
  endtask

  vec_t vt [22];

  initial begin
    n_pass = 0;
    n_total = 0;
    stb_cnt = 0;
    vt[0]  = '{2'b11, 20, 2'd0, 2'b00, 0};
    vt[1]  = '{2'b10, 20, 2'd1, 2'b01, 1};
    vt[2]  = '{2'b11, 20, 2'd1, 2'b00, 0};
    vt[3]  = '{2'b10, 12, 2'd2, 2'b01, 1};
    vt[4]  = '{2'b11, 12, 2'd2, 2'b00, 0};
    vt[5]  = '{2'b10, 12, 2'd3, 2'b01, 1};
    vt[6]  = '{2'b11, 12, 2'd3, 2'b00, 0};
    vt[7]  = '{2'b10, 12, 2'd0, 2'b01, 1};
    vt[8]  = '{2'b11, 12, 2'd0, 2'b00, 0};
    vt[9]  = '{2'b01, 12, 2'd3, 2'b10, 1};
    vt[10] = '{2'b11, 12, 2'd3, 2'b00, 0};
    vt[11] = '{2'b10, 12, 2'd0, 2'b01, 1};
    vt[12] = '{2'b11, 12, 2'd0, 2'b00, 0};
    vt[13] = '{2'b10, 12, 2'd1, 2'b01, 1};
    vt[14] = '{2'b11, 12, 2'd1, 2'b00, 0};
    vt[15] = '{2'b10, 12, 2'd2, 2'b01, 1};
    vt[16] = '{2'b11, 12, 2'd2, 2'b00, 0};
    vt[17] = '{2'b00, 12, 2'd0, 2'b11, 1};
    vt[18] = '{2'b11, 12, 2'd0, 2'b00, 0};
    vt[19] = '{2'b10, 12, 2'd1, 2'b01, 1};
    vt[20] = '{2'b00, 12, 2'd0, 2'b11, 1};
    vt[21] = '{2'b11, 12, 2'd0, 2'b00, 0};

    rst = 1'b1;
    key = 2'b11;
    tick();
    tick();
    check("rst_mode", {6'b0, mode}, 8'd0);
    check("rst_stb", {7'b0, strobe}, 8'd0);
    check("rst_kp", {6'b0, kp}, 8'd0);
    rst = 1'b0;

    for (int v = 0; v < 22; v++) begin
      key = vt[v].key;
      stb_cnt = 0;
      for (int c = 0; c < vt[v].cycles; c++) tick();
      check($sformatf("vec%0d_mode", v), {6'b0, mode},
            {6'b0, vt[v].exp_mode});
      check($sformatf("vec%0d_kp", v), {6'b0, kp},
            {6'b0, vt[v].exp_kp});
      check($sformatf("vec%0d_stb", v), 8'(stb_cnt),
            8'(vt[v].exp_stb));
    end

    // clean press: strobe only on the 7th edge after driving
    key = 2'b10;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("press_t%0d_stb", c), {7'b0, strobe},
            {7'b0, c == 7});
      check($sformatf("press_t%0d_kp", c), {6'b0, kp},
            {6'b0, 1'b0, c >= 7});
    end
    check("press_mode", {6'b0, mode}, 8'd1);
    key = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("rel_t%0d_kp", c), {6'b0, kp},
            {6'b0, 1'b0, c < 7});
      check($sformatf("rel_t%0d_stb", c), {7'b0, strobe}, 8'd0);
    end

    // bounce: 2 low, 1 high, 3 low, 1 high, then stable low
    stb_cnt = 0;
    key = 2'b10; tick(); tick();
    key = 2'b11; tick();
    key = 2'b10; tick(); tick(); tick();
    key = 2'b11; tick();
    key = 2'b10;
    for (int c = 1; c <= 6; c++) tick();
    check("bounce_quiet", 8'(stb_cnt), 8'd0);
    tick();
    check("bounce_stb", {7'b0, strobe}, 8'd1);
    check("bounce_mode", {6'b0, mode}, 8'd2);
    for (int c = 0; c < 5; c++) tick();
    check("bounce_total", 8'(stb_cnt), 8'd1);
    key = 2'b11;
    for (int c = 0; c < 12; c++) tick();

    // reset two edges before commit; held key must re-qualify
    key = 2'b10;
    stb_cnt = 0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_mode", {6'b0, mode}, 8'd0);
    check("rstmid_kp", {6'b0, kp}, 8'd0);
    for (int c = 1; c <= 6; c++) tick();
    check("rstmid_quiet", 8'(stb_cnt), 8'd0);
    check("rstmid_mode0", {6'b0, mode}, 8'd0);
    tick();
    check("rstmid_stb", {7'b0, strobe}, 8'd1);
    check("rstmid_mode1", {6'b0, mode}, 8'd1);
    key = 2'b11;
    for (int c = 0; c < 12; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
